// File: rtl/divider_signed.sv
// Sequential radix-2 signed divider: 2N-bit dividend by N-bit divisor.
// Restoring division on magnitudes, sign-corrected results held until accepted.
module divider_signed #(
    parameter int N = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  qacc;
    logic [N-1:0]  racc;
    logic [N-1:0]  dmag;
    logic [CW-1:0] cnt;
    logic          negq;
    logic          negr;

    logic [W-1:0]  amag_in;
    logic [N-1:0]  dmag_in;
    logic [N:0]    shifted;
    logic          take;
    logic [W-1:0]  qnext;
    logic [N-1:0]  rnext;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    // Unsigned magnitudes; the most negative values map to 2^(k-1) exactly.
    always_comb begin
        amag_in = dividend[W-1] ? -dividend : dividend;
        dmag_in = divisor[N-1] ? -divisor : divisor;
    end

    // Partial remainder stays below |divisor| <= 2^(N-1), so N bits suffice.
    always_comb begin
        shifted = {racc, qacc[W-1]};
        take    = (shifted >= {1'b0, dmag});
        rnext   = take ? (shifted[N-1:0] - dmag) : shifted[N-1:0];
        qnext   = {qacc[W-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            qacc        <= '0;
            racc        <= '0;
            dmag        <= '0;
            cnt         <= '0;
            negq        <= 1'b0;
            negr        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        qacc <= amag_in;
                        dmag <= dmag_in;
                        racc <= '0;
                        cnt  <= '0;
                        negq <= dividend[W-1] ^ divisor[N-1];
                        negr <= dividend[W-1];
                        if (divisor == '0) begin
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    qacc <= qnext;
                    racc <= rnext;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        quotient    <= negq ? -qnext : qnext;
                        remainder   <= negr ? -rnext : rnext;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_signed.sv
// Scoreboard bench for divider_signed: directed corner cases plus
// randomized operands checked against plain signed arithmetic.
module tb_divider_signed;

    localparam int N = 17;
    localparam int W = 2 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    divider_signed #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold     = 1'b0;
    bit   rand_bp  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [N-1:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (sb_ == 0) begin
            e.q = '0;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
            e.q = q[W-1:0];
            e.r = r[N-1:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Consumer side: backpressure generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold) out_ready = 1'b0;
            else if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
        end
    end

    // Monitor: every presented result must match the oldest expectation,
    // and stay equal to it for as long as it is stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = sb[0];
                    chk("quotient", 64'(quotient), 64'(e.q));
                    chk("remainder", 64'(remainder), 64'(e.r));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Issue one operation; optionally wait for the result and report the
    // cycle (1 = cycle right after the firing edge) where out_valid is seen.
    task automatic issue(input logic [W-1:0] a, input logic [N-1:0] b,
                         input bit wait_done, output int lat);
        int  tries;
        bit  fired;
        lat = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        fired = 1'b0;
        for (tries = 0; tries < 200; tries++) begin
            @(negedge clk);
            if (in_ready) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) begin
            chk("in_ready_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
        dividend = W'({$urandom, $urandom});
        divisor  = N'($urandom);
        if (!wait_done) return;
        lat = 1;
        for (tries = 0; tries < 200; tries++) begin
            @(negedge clk);
            if (out_valid) return;
            lat++;
        end
        chk("out_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    task automatic dir(input logic [W-1:0] a, input logic [N-1:0] b,
                       input int exp_lat);
        int lat;
        issue(a, b, 1'b1, lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        drain();
    endtask

    localparam int LAT = 2 * N + 1;

    initial begin
        logic [W-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] amin;
        logic [N-1:0] bmin;
        int           lat;

        amin = '0;
        amin[W-1] = 1'b1;
        bmin = '0;
        bmin[N-1] = 1'b1;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_quotient", 64'(quotient), 64'(0));
        chk("rst_remainder", 64'(remainder), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'(1));

        dir(W'(100), N'(7), LAT);
        dir(-W'(100), N'(7), LAT);
        dir(W'(100), -N'(7), LAT);
        dir(-W'(100), -N'(7), LAT);
        dir(W'(12345), N'(0), 1);
        dir(amin, -N'(1), LAT);
        dir(~amin, -N'(65536), LAT);
        dir(amin, bmin, LAT);
        dir(amin, N'(0), 1);
        dir(~amin, N'(1), LAT);

        // Backpressure: stall in DONE, poke in_valid, then release.
        hold = 1'b1;
        issue(W'(1000), N'(9), 1'b1, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = N'($urandom_range(0, 3));
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 20 && out_valid; i++) @(negedge clk);
        chk("drain_out_valid", 64'(out_valid), 64'(0));
        chk("drain_in_ready", 64'(in_ready), 64'(1));
        chk("bp_no_extra", 64'(sb.size()), 64'(0));
        dir(W'(77), N'(5), LAT);

        // Reset in the middle of CALC aborts the operation.
        issue(W'(100), N'(7), 1'b0, lat);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(0));
        chk("abort_quotient", 64'(quotient), 64'(0));
        chk("abort_remainder", 64'(remainder), 64'(0));
        chk("abort_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready_release", 64'(in_ready), 64'(1));
        repeat (3) @(negedge clk);
        chk("abort_no_result", 64'(out_valid), 64'(0));
        dir(W'(100), N'(7), LAT);

        // Randomized operands with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = W'({$urandom, $urandom});
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = -N'(1);
                2: b = bmin;
                3: b = N'($urandom_range(1, 15));
                default: b = N'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = amin;
            issue(a, b, 1'b1, lat);
            chk("rand_latency", 64'(lat), 64'((b == '0) ? 1 : LAT));
        end
        rand_bp = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider_signed.md
DIVIDER_SIGNED -- requirements
Module: divider_signed

Interface
REQ-001 Parameter: N, default 17, divisor/remainder width; dividend/quotient width is 2*N.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  2N  signed two's-complement dividend.
REQ-007 divisor  input  N  signed two's-complement divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  2N  signed quotient.
REQ-011 remainder  output  N  signed remainder.
REQ-012 div_by_zero  output  1  set with result when divisor was zero.

Function
REQ-013 The block SHALL be a sequential radix-2 divider with states IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an input fires on a rising edge with in_valid=1 and in_ready=1.
REQ-015 On fire, the block SHALL register the operand magnitudes and signs; operands may change afterwards without effect.
REQ-016 On fire with divisor!=0, next state SHALL be CALC for exactly 2N cycles, one quotient bit per cycle on unsigned magnitudes, MSB first.
REQ-017 After the 2N-th CALC cycle, state SHALL become DONE with sign-corrected results registered, so out_valid rises 2N+1 cycles after the firing edge.
REQ-018 Division SHALL truncate toward zero: quotient negative iff operand signs differ and magnitude nonzero; remainder takes the dividend's sign; dividend = quotient*divisor + remainder with |remainder| < |divisor|.
REQ-019 Magnitude of -2^(N-1) divisor and -2^(2N-1) dividend SHALL be handled as unsigned 2^(N-1) / 2^(2N-1) without loss.
REQ-020 Overflow case dividend=-2^(2N-1), divisor=-1 SHALL yield quotient=-2^(2N-1) (two's-complement wrap), remainder=0, div_by_zero=0.
REQ-021 On fire with divisor=0, the block SHALL skip CALC and enter DONE on the next edge with quotient=0, remainder=0, div_by_zero=1.
REQ-022 In DONE, out_valid=1 and quotient/remainder/div_by_zero SHALL hold stable until out_ready=1 at a rising edge.
REQ-023 On the edge where out_valid=1 and out_ready=1, state SHALL return to IDLE; in_ready rises in the following cycle (no same-cycle accept-after-drain).
REQ-024 out_valid SHALL be 0 in IDLE and CALC; quotient/remainder retain their last result outside DONE.
REQ-025 in_valid while not in IDLE SHALL be ignored (no fire, no state change).
REQ-026 Throughput SHALL be one operation per 2N+2 cycles minimum with out_ready held high.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, in_ready=0 while asserted, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation; no result is presented after release.
REQ-029 After rst_n deassertion, in_ready SHALL be 1 in the first cycle.

Verification
REQ-030 N=17: dividend=100, divisor=7 -> out_valid exactly 35 cycles after fire; quotient=14, remainder=2, div_by_zero=0.
REQ-031 Signs: -100/7 -> q=-14, r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
REQ-032 dividend=12345, divisor=0 -> out_valid one cycle after fire; q=0, r=0, div_by_zero=1.
REQ-033 Extremes: dividend=-2^33, divisor=-1 -> q=-2^33, r=0; dividend=2^33-1, divisor=-2^16 -> q=-131071, r=65535.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE, next op correct.
REQ-035 Assert rst_n=0 mid-CALC (cycle 10) -> immediate IDLE, out_valid=0, outputs zero; after release a new 100/7 returns q=14, r=2.
